ex_mem_latch: RTL and testbench
===============================

Name: ex_mem_latch

Overview:
- EX/MEM pipeline register of the MIPS core; sits directly downstream of the EX-stage branch-target adder and the ALU.
- Captures the branch target, ALU result, zero flag, store data, destination register and MEM/WB control bits.
- Resolves conditional branches in MEM: drives the PC-select pulse to fetch and the flush pulse to IF/ID and ID/EX.
- Squashes the single wrong-path instruction arriving from EX.

Parameters:
- len, 32, datapath width (PC, branch target, ALU result, store data)
- nb_reg, 5, register-address width

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_add_execute  input  len  branch target from EX adder (pc+4 + (imm<<2))
- i_alu_result  input  len  ALU result / memory address
- i_zero  input  1  ALU zero flag
- i_data_rt  input  len  store data (rt value)
- i_write_reg  input  nb_reg  destination register
- i_valid  input  1  EX holds a real instruction
- i_branch  input  1  BEQ control
- i_branch_ne  input  1  BNE control (present only with BRANCH_NE_EN)
- i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg  input  1 each  MEM/WB control
- i_stall  input  1  memory-stage stall; hold register contents
- o_add_execute, o_alu_result, o_data_rt  output  len  latched values
- o_write_reg  output  nb_reg  latched destination
- o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg  output  1 each  latched control, gated by validity
- o_valid  output  1  register holds a real instruction
- o_pc_src  output  1  one-cycle pulse: fetch loads o_add_execute
- o_flush  output  1  one-cycle pulse: IF/ID and ID/EX become bubbles

Behaviour:
- Reset (i_rst=1 at edge): all outputs 0, o_valid=0, internal taken_done=0, squash_pending=0. Reset has priority over stall and load. Reset mid-branch cancels the pending pulse and squash.
- Load: at edge with i_stall=0, all data and control fields are registered; latency 1 cycle.
- o_valid <= i_valid & ~squash_eff, where squash_eff = squash_pending | o_pc_src.
- Squashed load: control outputs forced to 0. Data fields may load but are don't-care.
- Stall: at edge with i_stall=1, all fields hold.
- taken = o_valid & o_branch_q & o_zero_q. With the macro, taken also includes o_branch_ne_q & ~o_zero_q.
- o_pc_src = taken & ~taken_done (combinational from registered state).
- o_flush = o_pc_src.
- taken_done: set at the edge where o_pc_src=1. Cleared on any non-stalled load.
- Result: exactly one pulse per taken branch, even under multi-cycle stall.
- squash_pending: set at the edge where o_pc_src=1 and i_stall=1. Cleared at the next non-stalled load; that load becomes a bubble.
- If o_pc_src=1 and i_stall=0 at the same edge, the incoming EX instruction is squashed directly.
- Not-taken branch: no pulse; instruction passes with controls as supplied.
- i_valid=0: bubble captured; o_valid=0, controls 0.
- Back-to-back branches: the second is wrong-path and squashed, so no second pulse.
- Arithmetic: none; targets pass through at width len.

Optional Feature:
- Macro BRANCH_NE_EN.
- Defined: port i_branch_ne present and registered; BNE is taken when zero=0.
- Undefined: port absent; only BEQ resolves; no extra flop.

Decomposition:
- Shared include/package: len and nb_reg defaults, control-bit index localparams for the MEM/WB control bundle.
- One natural sub-module: branch_resolve, purely combinational, taking registered branch/branch_ne/zero/valid and producing taken.

Test Plan:
- Reset: drive i_rst=1 with all inputs=1, then release → all outputs 0 on the next cycle.
- BEQ taken: i_valid=1, i_branch=1, i_zero=1, i_add_execute=32'h0000_0040, no stall → next cycle o_add_execute=0x40, o_pc_src=o_flush=1 for exactly 1 cycle; the following EX instruction (i_valid=1, i_reg_write=1) is latched with o_valid=0, o_reg_write=0.
- BEQ not taken: i_zero=0 → o_pc_src never asserted; next instruction latched with o_valid=1.
- Taken branch under stall: i_stall=1 for 3 cycles after the branch loads → o_pc_src high for 1 cycle only; after the stall drops, the first load is a bubble; the second load has o_valid=1.
- Load passthrough: i_alu_result=0x1234, i_write_reg=5'd9, i_mem_read=1, i_mem_to_reg=1, i_reg_write=1 → identical values on outputs 1 cycle later; stall holds them.
- BRANCH_NE_EN: i_branch_ne=1, i_zero=0 → o_pc_src pulse. Without the macro, same stimulus with i_branch=0 → no pulse.

Source files
------------

// File: rtl/ex_mem_latch_pkg.sv
// Shared widths and MEM/WB control-bundle layout for the EX/MEM pipeline register.
// Control bits travel together as one small vector indexed by the CTL_* localparams.
package ex_mem_latch_pkg;

   localparam int LEN_DEFAULT    = 32;
   localparam int NB_REG_DEFAULT = 5;

   localparam int CTL_MEM_READ   = 0;
   localparam int CTL_MEM_WRITE  = 1;
   localparam int CTL_REG_WRITE  = 2;
   localparam int CTL_MEM_TO_REG = 3;
   localparam int CTL_W          = 4;

   typedef logic [CTL_W-1:0] ctl_t;

   function automatic ctl_t pack_ctl(
      input logic mem_read,
      input logic mem_write,
      input logic reg_write,
      input logic mem_to_reg
   );
      ctl_t c;
      c                 = '0;
      c[CTL_MEM_READ]   = mem_read;
      c[CTL_MEM_WRITE]  = mem_write;
      c[CTL_REG_WRITE]  = reg_write;
      c[CTL_MEM_TO_REG] = mem_to_reg;
      return c;
   endfunction

endpackage

// File: rtl/ex_mem_latch_branch_resolve.sv
// Combinational branch resolution from the registered EX/MEM branch state.
// BRANCH_NE_EN adds the BNE input (taken when zero is clear).
module branch_resolve (
   input  logic valid_i,
   input  logic branch_i,
`ifdef BRANCH_NE_EN
   input  logic branch_ne_i,
`endif
   input  logic zero_i,
   output logic taken_o
);

   logic beq_taken;

   assign beq_taken = branch_i & zero_i;

`ifdef BRANCH_NE_EN
   assign taken_o = valid_i & (beq_taken | (branch_ne_i & ~zero_i));
`else
   assign taken_o = valid_i & beq_taken;
`endif

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: latches EX results, resolves branches in MEM and squashes the
// one wrong-path instruction behind a taken branch. BRANCH_NE_EN enables BNE resolution.
module ex_mem_latch
   import ex_mem_latch_pkg::*;
#(
   parameter int len    = LEN_DEFAULT,
   parameter int nb_reg = NB_REG_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [len-1:0]    i_add_execute,
   input  logic [len-1:0]    i_alu_result,
   input  logic              i_zero,
   input  logic [len-1:0]    i_data_rt,
   input  logic [nb_reg-1:0] i_write_reg,
   input  logic              i_valid,
   input  logic              i_branch,
`ifdef BRANCH_NE_EN
   input  logic              i_branch_ne,
`endif
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_reg_write,
   input  logic              i_mem_to_reg,
   input  logic              i_stall,
   output logic [len-1:0]    o_add_execute,
   output logic [len-1:0]    o_alu_result,
   output logic [len-1:0]    o_data_rt,
   output logic [nb_reg-1:0] o_write_reg,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic              o_reg_write,
   output logic              o_mem_to_reg,
   output logic              o_valid,
   output logic              o_pc_src,
   output logic              o_flush
);

   logic [len-1:0]    add_q, add_d;
   logic [len-1:0]    alu_q, alu_d;
   logic [len-1:0]    rt_q, rt_d;
   logic [nb_reg-1:0] wr_q, wr_d;
   ctl_t              ctl_q, ctl_d;
   logic              valid_q, valid_d;
   logic              branch_q, branch_d;
   logic              zero_q, zero_d;
   logic              taken_done_q, taken_done_d;
   logic              squash_pending_q, squash_pending_d;
`ifdef BRANCH_NE_EN
   logic              branch_ne_q, branch_ne_d;
`endif

   logic taken;
   logic pc_src;
   logic squash_eff;

   branch_resolve u_branch_resolve (
      .valid_i     (valid_q),
      .branch_i    (branch_q),
`ifdef BRANCH_NE_EN
      .branch_ne_i (branch_ne_q),
`endif
      .zero_i      (zero_q),
      .taken_o     (taken)
   );

   // The redirect fires once per resolved branch; taken_done blocks repeats while stalled.
   assign pc_src     = taken & ~taken_done_q;
   assign squash_eff = squash_pending_q | pc_src;

   always_comb begin
      add_d            = add_q;
      alu_d            = alu_q;
      rt_d             = rt_q;
      wr_d             = wr_q;
      ctl_d            = ctl_q;
      valid_d          = valid_q;
      branch_d         = branch_q;
      zero_d           = zero_q;
`ifdef BRANCH_NE_EN
      branch_ne_d      = branch_ne_q;
`endif
      taken_done_d     = taken_done_q | pc_src;
      squash_pending_d = squash_pending_q | pc_src;

      if (!i_stall) begin
         add_d            = i_add_execute;
         alu_d            = i_alu_result;
         rt_d             = i_data_rt;
         wr_d             = i_write_reg;
         valid_d          = i_valid & ~squash_eff;
         ctl_d            = valid_d ? pack_ctl(i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg)
                                    : '0;
         branch_d         = i_branch & valid_d;
         zero_d           = i_zero;
`ifdef BRANCH_NE_EN
         branch_ne_d      = i_branch_ne & valid_d;
`endif
         taken_done_d     = 1'b0;
         squash_pending_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         add_q            <= '0;
         alu_q            <= '0;
         rt_q             <= '0;
         wr_q             <= '0;
         ctl_q            <= '0;
         valid_q          <= 1'b0;
         branch_q         <= 1'b0;
         zero_q           <= 1'b0;
`ifdef BRANCH_NE_EN
         branch_ne_q      <= 1'b0;
`endif
         taken_done_q     <= 1'b0;
         squash_pending_q <= 1'b0;
      end else begin
         add_q            <= add_d;
         alu_q            <= alu_d;
         rt_q             <= rt_d;
         wr_q             <= wr_d;
         ctl_q            <= ctl_d;
         valid_q          <= valid_d;
         branch_q         <= branch_d;
         zero_q           <= zero_d;
`ifdef BRANCH_NE_EN
         branch_ne_q      <= branch_ne_d;
`endif
         taken_done_q     <= taken_done_d;
         squash_pending_q <= squash_pending_d;
      end
   end

   assign o_add_execute = add_q;
   assign o_alu_result  = alu_q;
   assign o_data_rt     = rt_q;
   assign o_write_reg   = wr_q;
   assign o_mem_read    = ctl_q[CTL_MEM_READ]   & valid_q;
   assign o_mem_write   = ctl_q[CTL_MEM_WRITE]  & valid_q;
   assign o_reg_write   = ctl_q[CTL_REG_WRITE]  & valid_q;
   assign o_mem_to_reg  = ctl_q[CTL_MEM_TO_REG] & valid_q;
   assign o_valid       = valid_q;
   assign o_pc_src      = pc_src;
   assign o_flush       = pc_src;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Self-checking bench for ex_mem_latch: directed scenarios then randomized traffic,
// all outputs compared each cycle against a behavioural pipeline model.
module tb_ex_mem_latch;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_add_execute, i_alu_result, i_data_rt;
   logic        i_zero;
   logic [4:0]  i_write_reg;
   logic        i_valid, i_branch, i_branch_ne;
   logic        i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg;
   logic        i_stall;
   logic [31:0] o_add_execute, o_alu_result, o_data_rt;
   logic [4:0]  o_write_reg;
   logic        o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg;
   logic        o_valid, o_pc_src, o_flush;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;

   always #5 i_clk = ~i_clk;

   ex_mem_latch dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_add_execute (i_add_execute),
      .i_alu_result  (i_alu_result),
      .i_zero        (i_zero),
      .i_data_rt     (i_data_rt),
      .i_write_reg   (i_write_reg),
      .i_valid       (i_valid),
      .i_branch      (i_branch),
`ifdef BRANCH_NE_EN
      .i_branch_ne   (i_branch_ne),
`endif
      .i_mem_read    (i_mem_read),
      .i_mem_write   (i_mem_write),
      .i_reg_write   (i_reg_write),
      .i_mem_to_reg  (i_mem_to_reg),
      .i_stall       (i_stall),
      .o_add_execute (o_add_execute),
      .o_alu_result  (o_alu_result),
      .o_data_rt     (o_data_rt),
      .o_write_reg   (o_write_reg),
      .o_mem_read    (o_mem_read),
      .o_mem_write   (o_mem_write),
      .o_reg_write   (o_reg_write),
      .o_mem_to_reg  (o_mem_to_reg),
      .o_valid       (o_valid),
      .o_pc_src      (o_pc_src),
      .o_flush       (o_flush)
   );

   // Model: the instruction held in MEM, whether its redirect was already issued,
   // and whether the next instruction entering from EX is wrong-path.
   typedef struct {
      logic [31:0] add, alu, rt;
      logic [4:0]  wr;
      logic        mr, mw, rw, m2r;
      logic        valid, beq, bne, zero;
      logic        known;
   } instr_t;

   instr_t m;
   bit     redirected;
   bit     kill_next;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_redirect();
      bit is_taken;
      is_taken = m.beq & m.zero;
`ifdef BRANCH_NE_EN
      is_taken = is_taken | (m.bne & ~m.zero);
`endif
      return m.valid & is_taken & !redirected;
   endfunction

   task automatic model_edge();
      bit redir;
      if (i_rst) begin
         m = '{add: 0, alu: 0, rt: 0, wr: 0, mr: 0, mw: 0, rw: 0, m2r: 0,
               valid: 0, beq: 0, bne: 0, zero: 0, known: 1};
         redirected = 0;
         kill_next  = 0;
         return;
      end
      redir = model_redirect();
      if (i_stall) begin
         if (redir) begin
            redirected = 1;
            kill_next  = 1;
         end
      end else begin
         m.valid    = i_valid && !(kill_next || redir);
         m.add      = i_add_execute;
         m.alu      = i_alu_result;
         m.rt       = i_data_rt;
         m.wr       = i_write_reg;
         m.mr       = m.valid & i_mem_read;
         m.mw       = m.valid & i_mem_write;
         m.rw       = m.valid & i_reg_write;
         m.m2r      = m.valid & i_mem_to_reg;
         m.beq      = i_branch;
         m.bne      = i_branch_ne;
         m.zero     = i_zero;
         m.known    = m.valid;
         redirected = 0;
         kill_next  = 0;
      end
   endtask

   task automatic compare_all();
      bit redir;
      redir = model_redirect();
      chk("pc_src",     64'(o_pc_src),     64'(redir));
      chk("flush",      64'(o_flush),      64'(redir));
      chk("valid",      64'(o_valid),      64'(m.valid));
      chk("mem_read",   64'(o_mem_read),   64'(m.mr));
      chk("mem_write",  64'(o_mem_write),  64'(m.mw));
      chk("reg_write",  64'(o_reg_write),  64'(m.rw));
      chk("mem_to_reg", 64'(o_mem_to_reg), 64'(m.m2r));
      if (m.known) begin
         chk("add_execute", 64'(o_add_execute), 64'(m.add));
         chk("alu_result",  64'(o_alu_result),  64'(m.alu));
         chk("data_rt",     64'(o_data_rt),     64'(m.rt));
         chk("write_reg",   64'(o_write_reg),   64'(m.wr));
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_edge();
      #1;
      if (o_pc_src) pulses++;
      compare_all();
   endtask

   task automatic clr_in();
      i_rst = 0; i_add_execute = 0; i_alu_result = 0; i_data_rt = 0; i_zero = 0;
      i_write_reg = 0; i_valid = 0; i_branch = 0; i_branch_ne = 0; i_mem_read = 0;
      i_mem_write = 0; i_reg_write = 0; i_mem_to_reg = 0; i_stall = 0;
   endtask

   initial begin
      redirected = 0;
      kill_next  = 0;
      m = '{add: 0, alu: 0, rt: 0, wr: 0, mr: 0, mw: 0, rw: 0, m2r: 0,
            valid: 0, beq: 0, bne: 0, zero: 0, known: 0};

      // reset with every input high
      i_rst = 1; i_add_execute = '1; i_alu_result = '1; i_data_rt = '1; i_zero = 1;
      i_write_reg = '1; i_valid = 1; i_branch = 1; i_branch_ne = 1; i_mem_read = 1;
      i_mem_write = 1; i_reg_write = 1; i_mem_to_reg = 1; i_stall = 1;
      tick();
      tick();
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_alu",   64'(o_alu_result), 64'd0);

      // BEQ taken, then the wrong-path instruction
      clr_in();
      i_valid = 1; i_branch = 1; i_zero = 1; i_add_execute = 32'h0000_0040;
      tick();
      chk("beq_target", 64'(o_add_execute), 64'h40);
      chk("beq_pulse",  64'(o_pc_src), 64'd1);
      clr_in();
      i_valid = 1; i_reg_write = 1;
      tick();
      chk("beq_squash_valid", 64'(o_valid), 64'd0);
      chk("beq_squash_rw",    64'(o_reg_write), 64'd0);
      chk("beq_one_pulse",    64'(o_pc_src), 64'd0);

      // BEQ not taken
      clr_in();
      i_valid = 1; i_branch = 1; i_zero = 0;
      tick();
      chk("bnt_no_pulse", 64'(o_pc_src), 64'd0);
      clr_in();
      i_valid = 1; i_reg_write = 1;
      tick();
      chk("bnt_next_valid", 64'(o_valid), 64'd1);

      // taken branch held by a 3-cycle stall
      clr_in();
      pulses = 0;
      i_valid = 1; i_branch = 1; i_zero = 1; i_add_execute = 32'h0000_0100;
      tick();
      clr_in();
      i_stall = 1; i_valid = 1; i_reg_write = 1;
      repeat (3) tick();
      i_stall = 0;
      tick();
      chk("stall_bubble", 64'(o_valid), 64'd0);
      tick();
      chk("stall_second_valid", 64'(o_valid), 64'd1);
      chk("stall_pulse_count", 64'(pulses), 64'd1);

      // plain load passthrough, then hold under stall
      clr_in();
      i_valid = 1; i_alu_result = 32'h1234; i_write_reg = 5'd9;
      i_mem_read = 1; i_mem_to_reg = 1; i_reg_write = 1;
      tick();
      chk("pass_alu", 64'(o_alu_result), 64'h1234);
      chk("pass_wr",  64'(o_write_reg), 64'd9);
      chk("pass_m2r", 64'(o_mem_to_reg), 64'd1);
      i_stall = 1; i_alu_result = 32'hdead; i_write_reg = 5'd3; i_mem_read = 0;
      tick();
      chk("hold_alu", 64'(o_alu_result), 64'h1234);
      chk("hold_mr",  64'(o_mem_read), 64'd1);

      // BNE (only resolves when the option is built in)
      clr_in();
      i_valid = 1; i_branch_ne = 1; i_zero = 0;
      tick();
`ifdef BRANCH_NE_EN
      chk("bne_pulse", 64'(o_pc_src), 64'd1);
`else
      chk("bne_no_pulse", 64'(o_pc_src), 64'd0);
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         i_rst         = ($urandom_range(0, 99) < 2);
         i_add_execute = $urandom;
         i_alu_result  = $urandom;
         i_data_rt     = $urandom;
         i_write_reg   = 5'($urandom);
         i_zero        = 1'($urandom);
         i_valid       = ($urandom_range(0, 9) < 8);
         i_branch      = ($urandom_range(0, 9) < 3);
         i_branch_ne   = ($urandom_range(0, 9) < 3);
         i_mem_read    = 1'($urandom);
         i_mem_write   = 1'($urandom);
         i_reg_write   = 1'($urandom);
         i_mem_to_reg  = 1'($urandom);
         i_stall       = ($urandom_range(0, 9) < 3);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
